// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared defaults and types for the shared-adder round-robin arbiter
package adder_arb_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 32;
    typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;
    typedef enum logic {EMPTY, FULL} out_state_t;
endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any_grant
);
    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        // scan from the farthest offset down so the nearest valid requester wins
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
                any_grant = 1'b1;
            end
        grant = '0;
        grant[grant_idx] = any_grant;
    end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one registered adder among NUM_REQ requesters
// Optional signed-overflow output rsp_ovf enabled by defining ADDER_ARB_OVF_EN
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                     rsp_ovf
`endif
);
    localparam int IW = $clog2(NUM_REQ);

    out_state_t         state, state_d;
    logic [IW-1:0]      rr_ptr, owner, gidx;
    logic [NUM_REQ-1:0] gnt;
    logic               any, drain, accept;
    logic [WIDTH-1:0]   a, b, sum, sum_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (gnt),
        .grant_idx (gidx),
        .any_grant (any)
    );

    assign a   = req_a[gidx*WIDTH +: WIDTH];
    assign b   = req_b[gidx*WIDTH +: WIDTH];
    assign sum = a + b;

    // the single output slot frees up in the same cycle its owner drains it
    assign drain  = (state == FULL) && rsp_ready[owner];
    assign accept = !rst && any && ((state == EMPTY) || drain);

    always_ff @(posedge clk)
        state <= rst ? EMPTY : state_d;

    always_comb
        state_d = accept ? FULL : drain ? EMPTY : state;

    always_comb begin
        req_ready = accept ? gnt : '0;
        rsp_valid = '0;
        rsp_valid[owner] = (state == FULL);
    end

    always_ff @(posedge clk)
        if (rst) begin
            rr_ptr <= '0;
            owner  <= '0;
            sum_q  <= '0;
        end else if (accept) begin
            rr_ptr <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            owner  <= gidx;
            sum_q  <= sum;
        end

    assign rsp_sum = sum_q;

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk)
        if (rst)
            ovf_q <= 1'b0;
        else if (accept)
            ovf_q <= (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    assign rsp_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and randomized checks of adder_arbiter against a reference model
module tb_adder_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   rsp_sum;
`ifdef ADDER_ARB_OVF_EN
    logic           rsp_ovf;
    logic           m_ovf;
`endif

    int           passed = 0;
    int           total = 0;
    int           m_ptr, m_owner;
    bit           m_full;
    logic [W-1:0] m_sum, held;
    logic [N-1:0] last_ready;

    always #5 clk = ~clk;

    adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum)
`ifdef ADDER_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // winner under the round-robin rule, or -1 when nothing may be accepted
    function automatic int winner();
        if (rst || (m_full && !rsp_ready[m_owner])) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic cycle(input string tag);
        int w;
        logic [W-1:0] a, b;
        logic [N-1:0] er;
        @(negedge clk);
        w = winner();
        er = (w < 0) ? '0 : N'(1) << w;
        last_ready = req_ready;
        chk({tag, ".req_ready"}, req_ready, er);
        if (rst) begin
            m_full = 0; m_ptr = 0; m_owner = 0; m_sum = '0;
`ifdef ADDER_ARB_OVF_EN
            m_ovf = 1'b0;
`endif
        end else if (w >= 0) begin
            a = req_a[w*W +: W];
            b = req_b[w*W +: W];
            m_sum = a + b;
`ifdef ADDER_ARB_OVF_EN
            m_ovf = ($signed({a[W-1], a}) + $signed({b[W-1], b})) > 33'sh0_7FFF_FFFF ||
                    ($signed({a[W-1], a}) + $signed({b[W-1], b})) < -33'sh0_8000_0000;
`endif
            m_owner = w;
            m_ptr = (w + 1) % N;
            m_full = 1;
        end else if (m_full && rsp_ready[m_owner]) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".rsp_valid"}, rsp_valid, m_full ? N'(1) << m_owner : '0);
        chk({tag, ".rsp_sum"}, rsp_sum, m_sum);
`ifdef ADDER_ARB_OVF_EN
        chk({tag, ".rsp_ovf"}, rsp_ovf, m_ovf);
`endif
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        set_op(0, 32'h1, 32'h2);
        req_valid = 4'b1111;
        cycle("reset0");
        cycle("reset1");
        chk("reset.rsp_valid", rsp_valid, 4'b0000);
        chk("reset.rsp_sum", rsp_sum, 32'h0);
        rst = 1'b0;
        req_valid = '0;

        set_op(2, 32'h0040_0000, 32'h4);
        req_valid = 4'b0100;
        cycle("single");
        chk("single.grant", last_ready, 4'b0100);
        chk("single.valid", rsp_valid, 4'b0100);
        chk("single.sum", rsp_sum, 32'h0040_0004);

        rst = 1'b1;
        req_valid = '0;
        cycle("rr_reset");
        rst = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
            cycle("rr");
            chk("rr.grant", last_ready, 4'b0001 << (g % N));
            chk("rr.valid", rsp_valid, 4'b0001 << (g % N));
        end

        req_valid = '0;
        cycle("drain");
        set_op(1, 32'h7FFF_FFFF, 32'h1);
        req_valid = 4'b0010;
        cycle("ovf_pos");
        chk("ovf_pos.sum", rsp_sum, 32'h8000_0000);
`ifdef ADDER_ARB_OVF_EN
        chk("ovf_pos.ovf", rsp_ovf, 1'b1);
`endif
        set_op(2, 32'hFFFF_FFFF, 32'h1);
        req_valid = 4'b0100;
        cycle("wrap");
        chk("wrap.sum", rsp_sum, 32'h0);
`ifdef ADDER_ARB_OVF_EN
        chk("wrap.ovf", rsp_ovf, 1'b0);
`endif

        set_op(1, 32'h1234_0000, 32'h0000_5678);
        req_valid = 4'b0010;
        cycle("bp_load");
        chk("bp_load.valid", rsp_valid, 4'b0010);
        held = rsp_sum;
        set_op(3, 32'h10, 32'h20);
        req_valid = 4'b1000;
        rsp_ready = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            cycle("bp_stall");
            chk("bp_stall.ready", last_ready, 4'b0000);
            chk("bp_stall.sum", rsp_sum, held);
        end
        rsp_ready = 4'b0010;
        cycle("bp_release");
        chk("bp_release.ready", last_ready, 4'b1000);
        chk("bp_release.valid", rsp_valid, 4'b1000);
        chk("bp_release.sum", rsp_sum, 32'h30);

        rsp_ready = '0;
        rst = 1'b1;
        req_valid = 4'b1001;
        set_op(0, 32'h5, 32'h6);
        cycle("midrst");
        chk("midrst.valid", rsp_valid, 4'b0000);
        chk("midrst.sum", rsp_sum, 32'h0);
        rst = 1'b0;
        cycle("after_rst");
        chk("after_rst.grant", last_ready, 4'b0001);

        rsp_ready = 4'b1110;
        req_valid = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            cycle("nonowner");
            chk("nonowner.ready", last_ready, 4'b0000);
            chk("nonowner.valid", rsp_valid, 4'b0001);
            chk("nonowner.sum", rsp_sum, 32'hB);
        end

        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) set_op(i, 32'h7FFF_FFFF - $urandom_range(0, 2), $urandom_range(0, 3));
                else set_op(i, $urandom, $urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
